// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory,
// holding the core in reset until the requested word count has been written.
module imem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_SIZE      = 256,
  parameter int CNT_WIDTH     = $clog2(MEM_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [CNT_WIDTH-1:0]     num_words_i,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_i,
  output logic                     byte_ready_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  output logic                     cpu_rst_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
  state_t                   state_q, state_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [CNT_WIDTH-1:0]     word_idx_q, word_idx_d, count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    asm_q, asm_d, wdata_q;
  logic                     ready_q, we_q, cpu_rst_q, busy_q, done_q, error_q;
  logic                     accept, legal;
  assign accept = ready_q && byte_valid_i;
  assign legal  = (num_words_i != '0) && (num_words_i <= CNT_WIDTH'(MEM_SIZE));
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    base_d     = base_q;
    asm_d      = asm_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_i) begin
        state_d = legal ? RECV : ERR;
        if (legal) begin
          count_d    = num_words_i;
          base_d     = base_addr_i & ~ADDRESS_WIDTH'(3);
          byte_idx_d = '0;
          word_idx_d = '0;
          asm_d      = '0;
        end
      end
      RECV: if (accept) begin
        asm_d[{byte_idx_q, 3'b000} +: 8] = byte_i;
        byte_idx_d = byte_idx_q + 2'd1;
        state_d    = (byte_idx_q == 2'd3) ? WRITE : RECV;
      end
      WRITE: begin
        word_idx_d = word_idx_q + CNT_WIDTH'(1);
        byte_idx_d = '0;
        state_d    = (word_idx_d == count_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
    addr_d = (state_d == WRITE) ? base_q + (ADDRESS_WIDTH'(word_idx_q) << 2) : addr_q;
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      base_q     <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      base_q     <= base_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      wdata_q    <= (state_d == WRITE) ? asm_d : wdata_q;
      ready_q    <= state_d == RECV;
      we_q       <= state_d == WRITE;
      cpu_rst_q  <= state_d != DONE;
      busy_q     <= (state_d == RECV) || (state_d == WRITE);
      done_q     <= state_d == DONE;
      error_q    <= state_d == ERR;
    end
  end
  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus hand-written sequences for the instruction memory loader.
module tb_imem_loader;
  logic        clk = 0, rst = 1, start_i = 0, byte_valid_i = 0;
  logic [8:0]  num_words_i = 0;
  logic [31:0] base_addr_i = 0;
  logic [7:0]  byte_i = 0;
  logic        byte_ready_o, mem_we_o, cpu_rst_o, busy_o, done_o, error_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  int n_chk = 0, n_fail = 0, rdy_viol = 0;
  logic [31:0] wa[$], wd[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_words_i(num_words_i), .base_addr_i(base_addr_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .cpu_rst_o(cpu_rst_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we_o) begin
    wa.push_back(mem_addr_o);
    wd.push_back(mem_wdata_o);
    if (byte_ready_o) rdy_viol++;
  end

  typedef struct {
    logic        start;
    logic [8:0]  num;
    logic [31:0] base;
    logic        valid;
    logic [7:0]  b;
    logic [5:0]  flags;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  function automatic logic [69:0] outs();
    return {byte_ready_o, mem_we_o, cpu_rst_o, busy_o, done_o, error_o, mem_addr_o, mem_wdata_o};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [8:0] n, input logic [31:0] base);
    start_i = 1; num_words_i = n; base_addr_i = base;
    tick();
    start_i = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    int t = 0;
    byte_valid_i = 1; byte_i = b;
    forever begin
      got = byte_ready_o;
      tick();
      if (got) break;
      if (++t > 20) begin
        chk("byte_accept_timeout", 0, 1);
        break;
      end
    end
    byte_valid_i = 0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input string name, input int lim);
    for (int i = 0; i < lim && !done_o; i++) tick();
    chk(name, {done_o, cpu_rst_o}, 2'b10);
  endtask

  vec_t v[12];
  logic [31:0] w, exp_last;
  int n, bad;

  initial begin
    // flags = {ready, we, cpu_rst, busy, done, error}
    v[0]  = '{1, 2, 0, 0, 8'h00, 6'b101100, 32'h0, 32'h0};
    v[1]  = '{0, 0, 0, 1, 8'h13, 6'b101100, 32'h0, 32'h0};
    v[2]  = '{0, 0, 0, 1, 8'h05, 6'b101100, 32'h0, 32'h0};
    v[3]  = '{0, 0, 0, 1, 8'h10, 6'b101100, 32'h0, 32'h0};
    v[4]  = '{0, 0, 0, 1, 8'h00, 6'b011100, 32'h0, 32'h00100513};
    v[5]  = '{0, 0, 0, 1, 8'hB3, 6'b101100, 32'h0, 32'h00100513};
    v[6]  = '{0, 0, 0, 1, 8'hB3, 6'b101100, 32'h0, 32'h00100513};
    v[7]  = '{0, 0, 0, 1, 8'h05, 6'b101100, 32'h0, 32'h00100513};
    v[8]  = '{0, 0, 0, 1, 8'hB5, 6'b101100, 32'h0, 32'h00100513};
    v[9]  = '{0, 0, 0, 1, 8'h00, 6'b011100, 32'h4, 32'h00B505B3};
    v[10] = '{0, 0, 0, 0, 8'h00, 6'b000010, 32'h4, 32'h00B505B3};
    v[11] = '{0, 0, 0, 0, 8'h00, 6'b000010, 32'h4, 32'h00B505B3};

    tick();
    rst = 0;
    chk("reset_state", outs(), {6'b001000, 32'h0, 32'h0});

    for (int i = 0; i < 12; i++) begin
      start_i = v[i].start; num_words_i = v[i].num; base_addr_i = v[i].base;
      byte_valid_i = v[i].valid; byte_i = v[i].b;
      tick();
      chk($sformatf("vec%0d", i), outs(), {v[i].flags, v[i].addr, v[i].wdata});
    end
    start_i = 0; byte_valid_i = 0;

    // Stream with gaps between bytes
    wa.delete(); wd.delete();
    pulse_start(2, 0);
    send_word(32'h00100513, 1);
    send_word(32'h00B505B3, 1);
    wait_done("gap_done", 20);
    chk("gap_nwrites", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("gap_w0", {wa[0], wd[0]}, {32'h0, 32'h00100513});
      chk("gap_w1", {wa[1], wd[1]}, {32'h4, 32'h00B505B3});
    end
    chk("ready_low_in_write", rdy_viol, 0);

    // Illegal counts
    rst = 1; tick(); rst = 0;
    wa.delete(); wd.delete();
    pulse_start(0, 0);
    chk("err_zero", outs(), {6'b001001, 32'h0, 32'h0});
    pulse_start(257, 0);
    chk("err_over", {error_o, cpu_rst_o, busy_o}, 3'b110);
    chk("err_no_writes", wa.size(), 0);
    pulse_start(1, 32'h13);
    chk("err_recover", {error_o, byte_ready_o, cpu_rst_o}, 3'b011);
    send_word(32'hDEADBEEF, 0);
    wait_done("err_load_done", 10);
    chk("err_load_write", {32'(wa.size()), wa[0], wd[0]}, {32'd1, 32'h10, 32'hDEADBEEF});

    // Reset mid-load, then reload at 0x40
    rst = 1; tick(); rst = 0;
    pulse_start(3, 0);
    send_word(32'h11223344, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    wa.delete(); wd.delete();
    rst = 1; tick(); rst = 0;
    chk("midload_reset", outs(), {6'b001000, 32'h0, 32'h0});
    repeat (6) tick();
    chk("midload_no_write", wa.size(), 0);
    pulse_start(3, 32'h40);
    for (int i = 0; i < 3; i++) send_word(32'hC0DE0000 + i, 0);
    wait_done("reload_done", 10);
    chk("reload_addrs", {32'(wa.size()), wa[0], wa[1], wa[2]}, {32'd3, 32'h40, 32'h44, 32'h48});

    // Restart from DONE; start during RECV is ignored
    wa.delete(); wd.delete();
    pulse_start(1, 32'h100);
    chk("restart_cpu_rst", {cpu_rst_o, done_o, busy_o}, 3'b101);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    pulse_start(5, 32'h200);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    wait_done("restart_done", 10);
    chk("restart_write", {32'(wa.size()), wa[0], wd[0]}, {32'd1, 32'h100, 32'h04030201});

    // Full-depth load
    wa.delete(); wd.delete();
    pulse_start(256, 0);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], ~i[7:0], 8'hA5, i[7:0]};
      if (i == 255) begin
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
        chk("full_done_late", {mem_we_o, done_o}, 2'b10);
      end else send_word(w, 0);
    end
    wait_done("full_done", 5);
    chk("full_nwrites", wa.size(), 256);
    bad = 0;
    n = wa.size();
    for (int i = 0; i < n; i++) begin
      exp_last = {i[7:0], ~i[7:0], 8'hA5, i[7:0]};
      if (wa[i] !== 32'(i * 4) || wd[i] !== exp_last) bad++;
    end
    chk("full_contents", bad, 0);
    if (n > 0) chk("full_last_addr", wa[n-1], 32'h3FC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory, which the processor core reads.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit little-endian instruction words.
- Writes those words to consecutive word addresses of the instruction memory.
- Holds the core in reset while loading and releases it once the programmed word count has been written.

Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes.
- ADDRESS_WIDTH, 32, byte-address width of the instruction memory write port.
- MEM_SIZE, 256, instruction memory depth in words; upper limit for num_words_i.
- CNT_WIDTH, $clog2(MEM_SIZE)+1, width of the word-count input and internal word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; begins a load, and latches num_words_i and base_addr_i.
- num_words_i  in  CNT_WIDTH  number of words to load.
- base_addr_i  in  ADDRESS_WIDTH  byte address of the first word; bits [1:0] are ignored and treated as 0.
- byte_valid_i  in  1  source presents a byte.
- byte_i  in  8  byte data.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  instruction memory write strobe, one cycle per word.
- mem_addr_o  out  ADDRESS_WIDTH  write byte address.
- mem_wdata_o  out  DATA_WIDTH  write data.
- cpu_rst_o  out  1  reset to the processor core.
- busy_o  out  1  load in progress (RECV or WRITE state).
- done_o  out  1  load completed; core released.
- error_o  out  1  start_i arrived with an illegal count.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rst_o=1, busy_o=0, done_o=0, error_o=0. FSM goes to IDLE; byte index, word counter and assembly register clear to 0.
- A byte transfers only on a cycle where byte_valid_i && byte_ready_o. byte_i must be stable while byte_valid_i is high; the loader never drops an accepted byte.
- States:
  - IDLE: cpu_rst_o=1, byte_ready_o=0.
    - On start_i with 1 <= num_words_i <= MEM_SIZE: latch count and base, clear counters, go to RECV.
    - On start_i with num_words_i==0 or num_words_i>MEM_SIZE: go to ERR.
  - RECV: byte_ready_o=1, busy_o=1.
    - Accepted byte k (k=0..3) is placed in bits [8k+7:8k] of the assembly register.
    - After byte 3 is accepted, go to WRITE. byte_ready_o drops in the cycle after byte 3, so there is no back-to-back fifth accept.
  - WRITE: exactly one cycle. mem_we_o=1, mem_addr_o=base+4*word_idx, mem_wdata_o=assembled word, byte_ready_o=0.
    - Then word_idx increments.
    - If the new word_idx equals the latched count, go to DONE; otherwise go to RECV with the byte index back at 0.
  - DONE: done_o=1, cpu_rst_o=0, byte_ready_o=0.
    - start_i with a legal count re-enters RECV: done_o clears and cpu_rst_o re-asserts in the same edge.
    - start_i with an illegal count goes to ERR.
  - ERR: error_o=1, cpu_rst_o=1.
    - start_i with a legal count clears error_o and goes to RECV.
    - Otherwise the state holds until rst.
- Latency: mem_we_o is asserted in the cycle immediately after the cycle the 4th byte of a word is accepted. cpu_rst_o deasserts in the cycle after the final WRITE.
- Minimum time per word: 5 cycles (4 accepts + 1 write).
- mem_we_o is never high in any state other than WRITE. mem_addr_o and mem_wdata_o hold their last values outside WRITE.
- start_i is ignored in RECV and WRITE.
- Address arithmetic is modulo 2^ADDRESS_WIDTH with no bounds check against base. The count check against MEM_SIZE is the only range check.
- Reset mid-load: the partial word is discarded, no write is issued, and the block returns to IDLE with cpu_rst_o=1. Words already written stay in memory; the loader does not clear them.
- Source stalls (byte_valid_i low) are unbounded. There is no timeout.

Test Plan:
- Reset, then start_i with num_words_i=2 and base 0x0. Stream bytes 0x13,0x05,0x10,0x00,0xB3,0x05,0xB5,0x00 with no gaps.
  - Required: write 0x00100513 at address 0x0, then 0x00B505B3 at address 0x4.
  - Each mem_we_o is one cycle, one cycle after that word's 4th accept.
  - done_o=1 and cpu_rst_o=0 one cycle after the second write.
- Same stream with byte_valid_i toggling every other cycle.
  - Required: identical writes and data; no duplicated or lost bytes; byte_ready_o=0 during each WRITE.
- start_i with num_words_i=0, then with num_words_i=MEM_SIZE+1.
  - Required: error_o=1, cpu_rst_o=1, mem_we_o never asserted.
  - A following start_i with a count of 1 clears error_o and loads normally.
- Assert rst after the 2nd byte of word 1 of a 3-word load.
  - Required: no further mem_we_o; all outputs return to reset values next cycle.
  - A subsequent full load with base 0x40 writes addresses 0x40, 0x44, 0x48.
- From DONE, issue start_i with num_words_i=1.
  - Required: cpu_rst_o=1 and done_o=0 on the next cycle; one write; then DONE again.
  - start_i pulsed during RECV has no effect.
- Load num_words_i=MEM_SIZE=256 from base 0.
  - Required: 256 writes; last address is 0x3FC; done_o asserts only after the 256th write.
